// File: rtl/led_debug_mux.sv
// Registered LED debug selector: direct slice, button view, timed auto-scroll
// and sticky bit-change capture, with a hold input that freezes the LED bank.
module led_debug_mux #(
    parameter int NUM_REGS   = 4,
    parameter int REG_W      = 32,
    parameter int LED_W      = 8,
    parameter int BTN_W      = 16,
    parameter int SCROLL_DIV = 16777216
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic [NUM_REGS*REG_W-1:0]   regs,
    input  logic [BTN_W-1:0]            buttons,
    input  logic [7:0]                  SW,
    input  logic                        hold,
    output logic [LED_W-1:0]            LD,
    output logic [((NUM_REGS*REG_W/LED_W) > 1 ? $clog2(NUM_REGS*REG_W/LED_W) : 1)-1:0] scroll_idx
);

    localparam int SLICES  = NUM_REGS * REG_W / LED_W;
    localparam int BSLICES = BTN_W / LED_W;
    localparam int SEL_W   = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int DIV_W   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_BTN    = 2'b01;
    localparam logic [1:0] MODE_SCROLL = 2'b10;
    localparam logic [1:0] MODE_STICKY = 2'b11;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SLICES - 1);

    logic [LED_W-1:0] r_ld;
    logic [SEL_W-1:0] r_scroll_idx;
    logic [DIV_W-1:0] r_div;
    logic [LED_W-1:0] r_sticky;
    logic [LED_W-1:0] r_prev;
    logic [1:0]       r_mode_q;
    logic [5:0]       r_idx_q;

    logic [1:0]       w_mode;
    logic [5:0]       w_idx;
    logic             w_entry;
    logic             w_sticky_clr;
    logic [LED_W-1:0] w_sw_slice;
    logic [LED_W-1:0] w_btn_slice;
    logic [LED_W-1:0] w_scroll_slice;
    logic [LED_W-1:0] w_ld_next;

    assign w_mode       = SW[7:6];
    assign w_idx        = SW[5:0];
    assign w_entry      = (w_mode != r_mode_q);
    assign w_sticky_clr = w_entry || (w_idx != r_idx_q);

    // Slice selection; indices past the last slice read as zero.
    always_comb begin
        w_sw_slice     = {LED_W{1'b0}};
        w_btn_slice    = {LED_W{1'b0}};
        w_scroll_slice = {LED_W{1'b0}};
        for (int s = 0; s < SLICES; s++) begin
            w_sw_slice     = (int'(w_idx) == s) ? regs[s*LED_W +: LED_W] : w_sw_slice;
            w_scroll_slice = (r_scroll_idx == SEL_W'(s)) ? regs[s*LED_W +: LED_W] : w_scroll_slice;
        end
        for (int b = 0; b < BSLICES; b++) begin
            w_btn_slice = (int'(w_idx) == b) ? buttons[b*LED_W +: LED_W] : w_btn_slice;
        end
    end

    // Next LED value for the currently selected mode.
    always_comb begin
        w_ld_next = {LED_W{1'b0}};
        case (w_mode)
            MODE_DIRECT: w_ld_next = w_sw_slice;
            MODE_BTN:    w_ld_next = w_btn_slice;
            MODE_SCROLL: w_ld_next = w_scroll_slice;
            MODE_STICKY: w_ld_next = r_sticky;
            default:     w_ld_next = {LED_W{1'b0}};
        endcase
    end

    // Mode tracking, scroll divider/pointer, sticky capture and LED register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ld         <= {LED_W{1'b0}};
            r_scroll_idx <= {SEL_W{1'b0}};
            r_div        <= {DIV_W{1'b0}};
            r_sticky     <= {LED_W{1'b0}};
            r_prev       <= {LED_W{1'b0}};
            r_mode_q     <= 2'b00;
            r_idx_q      <= 6'd0;
        end else begin
            r_mode_q <= w_mode;
            r_idx_q  <= w_idx;
            case (w_mode)
                MODE_SCROLL: begin
                    if (w_entry) begin
                        r_scroll_idx <= {SEL_W{1'b0}};
                        r_div        <= {DIV_W{1'b0}};
                    end else if (!hold) begin
                        if (r_div == DIV_LAST) begin
                            r_div        <= {DIV_W{1'b0}};
                            r_scroll_idx <= (r_scroll_idx == SEL_LAST) ? {SEL_W{1'b0}}
                                                                       : r_scroll_idx + SEL_W'(1);
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end else begin
                        r_div <= r_div;
                    end
                end
                // Capture keeps accumulating through hold so no toggle is missed.
                MODE_STICKY: begin
                    r_prev <= w_sw_slice;
                    if (w_sticky_clr) begin
                        r_sticky <= {LED_W{1'b0}};
                    end else begin
                        r_sticky <= r_sticky | (w_sw_slice ^ r_prev);
                    end
                end
                default: begin
                    r_div <= r_div;
                end
            endcase
            if (!hold) begin
                r_ld <= w_ld_next;
            end else begin
                r_ld <= r_ld;
            end
        end
    end

    assign LD         = r_ld;
    assign scroll_idx = r_scroll_idx;

endmodule

// File: tb/tb_led_debug_mux.sv
// Directed self-checking bench for led_debug_mux (SCROLL_DIV overridden to 4).
module tb_led_debug_mux;

    logic         clk;
    logic         rst_b;
    logic [127:0] regs;
    logic [15:0]  buttons;
    logic [7:0]   SW;
    logic         hold;
    logic [7:0]   LD;
    logic [3:0]   scroll_idx;

    int total;
    int bad;

    led_debug_mux #(
        .NUM_REGS   (4),
        .REG_W      (32),
        .LED_W      (8),
        .BTN_W      (16),
        .SCROLL_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .regs       (regs),
        .buttons    (buttons),
        .SW         (SW),
        .hold       (hold),
        .LD         (LD),
        .scroll_idx (scroll_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int s);
        return 8'((s * 17 + 3) & 255);
    endfunction

    task automatic load_pattern();
        for (int s = 0; s < 16; s++) regs[s*8 +: 8] = pat(s);
    endtask

    task automatic test_reset();
        rst_b = 1'b0; regs = 128'd0; buttons = 16'd0; SW = 8'h00; hold = 1'b0;
        #2;
        total++;
        if (LD !== 8'h00) begin bad++; $display("FAIL reset_ld got=%h exp=00", LD); end
        total++;
        if (scroll_idx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", scroll_idx); end
        tick(); tick();
        rst_b = 1'b1;
        tick();
    endtask

    task automatic test_direct();
        regs[31:0] = 32'hA1B2C3D4;
        SW = 8'h02;
        #3;
        total++;
        if (LD !== 8'h00) begin bad++; $display("FAIL direct_latency got=%h exp=00", LD); end
        tick();
        total++;
        if (LD !== 8'hB2) begin bad++; $display("FAIL direct_s2 got=%h exp=b2", LD); end
        SW = 8'h03; tick();
        total++;
        if (LD !== 8'hA1) begin bad++; $display("FAIL direct_s3 got=%h exp=a1", LD); end
        SW = 8'h10; tick();
        total++;
        if (LD !== 8'h00) begin bad++; $display("FAIL direct_oor got=%h exp=00", LD); end
    endtask

    task automatic test_buttons();
        buttons = 16'h5AC3;
        SW = 8'h40; tick();
        total++;
        if (LD !== 8'hC3) begin bad++; $display("FAIL btn_0 got=%h exp=c3", LD); end
        SW = 8'h41; tick();
        total++;
        if (LD !== 8'h5A) begin bad++; $display("FAIL btn_1 got=%h exp=5a", LD); end
        SW = 8'h42; tick();
        total++;
        if (LD !== 8'h00) begin bad++; $display("FAIL btn_oor got=%h exp=00", LD); end
    endtask

    task automatic test_sticky();
        regs = 128'd0;
        SW = 8'hC0; tick(); tick();
        total++;
        if (LD !== 8'h00) begin bad++; $display("FAIL sticky_idle got=%h exp=00", LD); end
        regs[7:0] = 8'h05; tick();
        regs[7:0] = 8'h00; tick(); tick(); tick();
        total++;
        if (LD !== 8'h05) begin bad++; $display("FAIL sticky_capture got=%h exp=05", LD); end
        SW = 8'hC1; tick(); tick();
        total++;
        if (LD !== 8'h00) begin bad++; $display("FAIL sticky_idxclr got=%h exp=00", LD); end
    endtask

    task automatic test_sticky_hold();
        hold = 1'b1; tick();
        regs[15] = 1'b1; tick();
        regs[15] = 1'b0; tick();
        total++;
        if (LD !== 8'h00) begin bad++; $display("FAIL sticky_hold_frozen got=%h exp=00", LD); end
        hold = 1'b0; tick();
        total++;
        if (LD !== 8'h80) begin bad++; $display("FAIL sticky_hold_release got=%h exp=80", LD); end
    endtask

    task automatic test_autoscroll();
        load_pattern();
        SW = 8'h80; tick();
        total++;
        if (scroll_idx !== 4'd0) begin bad++; $display("FAIL scroll_entry got=%0d exp=0", scroll_idx); end
        for (int k = 1; k <= 64; k++) begin
            tick();
            total++;
            if (scroll_idx !== 4'((k / 4) % 16)) begin
                bad++; $display("FAIL scroll_idx k=%0d got=%0d exp=%0d", k, scroll_idx, (k / 4) % 16);
            end
            total++;
            if (LD !== pat(((k - 1) / 4) % 16)) begin
                bad++; $display("FAIL scroll_ld k=%0d got=%h exp=%h", k, LD, pat(((k - 1) / 4) % 16));
            end
        end
    endtask

    task automatic test_scroll_reenter();
        for (int k = 0; k < 13; k++) tick();
        total++;
        if (scroll_idx !== 4'd3) begin bad++; $display("FAIL reenter_pre got=%0d exp=3", scroll_idx); end
        SW = 8'h00; tick();
        total++;
        if (scroll_idx !== 4'd3) begin bad++; $display("FAIL reenter_held got=%0d exp=3", scroll_idx); end
        SW = 8'h80; tick();
        total++;
        if (scroll_idx !== 4'd0) begin bad++; $display("FAIL reenter_clear got=%0d exp=0", scroll_idx); end
        tick();
        total++;
        if (LD !== pat(0)) begin bad++; $display("FAIL reenter_ld got=%h exp=%h", LD, pat(0)); end
    endtask

    task automatic test_scroll_hold();
        SW = 8'h00; tick();
        SW = 8'h80; tick();
        for (int k = 0; k < 5; k++) tick();
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (scroll_idx !== 4'd1) begin bad++; $display("FAIL hold_idx k=%0d got=%0d exp=1", k, scroll_idx); end
            total++;
            if (LD !== pat(1)) begin bad++; $display("FAIL hold_ld k=%0d got=%h exp=%h", k, LD, pat(1)); end
        end
        hold = 1'b0;
        tick(); tick(); tick();
        total++;
        if (scroll_idx !== 4'd2) begin bad++; $display("FAIL hold_resume_idx got=%0d exp=2", scroll_idx); end
        tick();
        total++;
        if (LD !== pat(2)) begin bad++; $display("FAIL hold_resume_ld got=%h exp=%h", LD, pat(2)); end
    endtask

    task automatic test_reset_mid_scroll();
        SW = 8'h00; tick();
        SW = 8'h80; tick();
        for (int k = 0; k < 36; k++) tick();
        total++;
        if (scroll_idx !== 4'd9) begin bad++; $display("FAIL mid_pre got=%0d exp=9", scroll_idx); end
        #1 rst_b = 1'b0;
        #1;
        total++;
        if (LD !== 8'h00) begin bad++; $display("FAIL mid_rst_ld got=%h exp=00", LD); end
        total++;
        if (scroll_idx !== 4'd0) begin bad++; $display("FAIL mid_rst_idx got=%0d exp=0", scroll_idx); end
        rst_b = 1'b1;
        tick();
        total++;
        if (LD !== pat(0) || scroll_idx !== 4'd0) begin
            bad++; $display("FAIL mid_restart got=%h/%0d exp=%h/0", LD, scroll_idx, pat(0));
        end
        for (int k = 0; k < 4; k++) tick();
        total++;
        if (scroll_idx !== 4'd1 || LD !== pat(0)) begin
            bad++; $display("FAIL mid_step1 got=%h/%0d exp=%h/1", LD, scroll_idx, pat(0));
        end
        tick();
        total++;
        if (LD !== pat(1)) begin bad++; $display("FAIL mid_step1_ld got=%h exp=%h", LD, pat(1)); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_direct();
        test_buttons();
        test_sticky();
        test_sticky_hold();
        test_autoscroll();
        test_scroll_reenter();
        test_scroll_hold();
        test_reset_mid_scroll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
